// File: rtl/usb3300_rx_capture.sv
// usb3300_rx_capture: ULPI receive front end for the USB3300 PHY.
// Splits the bus into data, RX CMD and EOP entries and queues them show-ahead.
module usb3300_rx_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter bit CMD_DEDUP  = 1'b1
) (
    input  logic                        clk_ext,
    input  logic                        rst,
    input  logic [7:0]                  DATA,
    input  logic                        DIR,
    input  logic                        NXT,
    output logic                        STP,
    output logic [7:0]                  rx_byte,
    output logic [1:0]                  rx_tag,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        rx_active,
    output logic                        ovf,
    output logic [7:0]                  drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // bus phase, encoded as {dir_prev, dir_q}
    localparam logic [1:0] PH_IDLE     = 2'b00;
    localparam logic [1:0] PH_TURN_IN  = 2'b01;
    localparam logic [1:0] PH_TURN_OUT = 2'b10;
    localparam logic [1:0] PH_RX       = 2'b11;

    localparam logic [1:0] TAG_DATA    = 2'b00;
    localparam logic [1:0] TAG_CMD     = 2'b01;
    localparam logic [1:0] TAG_EOP_OK  = 2'b10;
    localparam logic [1:0] TAG_EOP_ERR = 2'b11;

    logic [7:0]    d_q;
    logic          dir_q;
    logic          nxt_q;
    logic          dir_prev_q;

    logic          rx_active_q, rx_active_d;
    logic [7:0]    pkt_len_q, pkt_len_d;
    logic          pkt_err_q, pkt_err_d;
    logic [7:0]    last_cmd_q, last_cmd_d;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic          wr_en;
    logic [9:0]    wr_ent;
    logic          eop;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            d_q        <= '0;
            dir_q      <= 1'b0;
            nxt_q      <= 1'b0;
            dir_prev_q <= 1'b0;
        end else begin
            d_q        <= DATA;
            dir_q      <= DIR;
            nxt_q      <= NXT;
            dir_prev_q <= dir_q;
        end
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_ent      = '0;
        eop         = 1'b0;
        rx_active_d = rx_active_q;
        pkt_len_d   = pkt_len_q;
        pkt_err_d   = pkt_err_q;
        last_cmd_d  = last_cmd_q;
        case ({dir_prev_q, dir_q})
            PH_TURN_IN: begin
                if (nxt_q) begin
                    rx_active_d = 1'b1;
                    pkt_len_d   = '0;
                end
            end
            PH_RX: begin
                if (nxt_q) begin
                    wr_en       = 1'b1;
                    wr_ent      = {TAG_DATA, d_q};
                    rx_active_d = 1'b1;
                    if (pkt_len_q != 8'hFF) begin
                        pkt_len_d = pkt_len_q + 8'd1;
                    end
                end else begin
                    if (d_q[5:4] == 2'b11) begin
                        pkt_err_d = 1'b1;
                    end
                    // RxActive low inside a packet closes it
                    if (rx_active_q && !d_q[4]) begin
                        eop = 1'b1;
                    end else if (!(CMD_DEDUP && d_q == last_cmd_q)) begin
                        wr_en      = 1'b1;
                        wr_ent     = {TAG_CMD, d_q};
                        last_cmd_d = d_q;
                    end
                end
            end
            PH_TURN_OUT: eop = rx_active_q;
            PH_IDLE: ;
            default: ;
        endcase
        if (eop) begin
            wr_en       = 1'b1;
            wr_ent      = {pkt_err_q ? TAG_EOP_ERR : TAG_EOP_OK, pkt_len_q};
            rx_active_d = 1'b0;
            pkt_err_d   = 1'b0;
            pkt_len_d   = '0;
        end
    end

    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid & rx_ready;
    assign full     = (count_q == FULL_CNT);
    assign push     = wr_en & (~full | pop);
    assign drop     = wr_en & full & ~pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            rx_active_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_err_q   <= 1'b0;
            last_cmd_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rx_active_q <= rx_active_d;
            pkt_len_q   <= pkt_len_d;
            pkt_err_q   <= pkt_err_d;
            last_cmd_q  <= last_cmd_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (push) begin
            mem_q[wptr_q] <= wr_ent;
        end
    end

    assign rx_byte   = rx_valid ? mem_q[rptr_q][7:0] : 8'h00;
    assign rx_tag    = rx_valid ? mem_q[rptr_q][9:8] : 2'b00;
    assign rx_active = rx_active_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;
    assign level     = count_q;
    assign STP       = 1'b0;

endmodule

// File: tb/tb_usb3300_rx_capture.sv
// tb_usb3300_rx_capture: directed packet scenarios plus randomized bus
// traffic checked against a queue-based model of the tagged byte stream.
module tb_usb3300_rx_capture;
    localparam int DEPTH = 16;

    logic       clk_ext = 1'b0;
    logic       rst;
    logic [7:0] DATA;
    logic       DIR;
    logic       NXT;
    logic       STP;
    logic [7:0] rx_byte;
    logic [1:0] rx_tag;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_active;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic [4:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    always #8 clk_ext = ~clk_ext;

    usb3300_rx_capture #(
        .FIFO_DEPTH(DEPTH),
        .CMD_DEDUP(1'b1)
    ) dut (
        .clk_ext(clk_ext),
        .rst(rst),
        .DATA(DATA),
        .DIR(DIR),
        .NXT(NXT),
        .STP(STP),
        .rx_byte(rx_byte),
        .rx_tag(rx_tag),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_active(rx_active),
        .ovf(ovf),
        .drop_cnt(drop_cnt),
        .level(level)
    );

    // model: the queue holds the tagged entries the consumer should see
    logic [9:0] mq[$];
    logic [7:0] m_d;
    bit         m_dir;
    bit         m_nxt;
    bit         m_prev;
    bit         m_act;
    bit         m_err;
    logic [7:0] m_len;
    logic [7:0] m_last;
    bit         m_ovf;
    int         m_drop;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit dir, input bit nxt,
                              input logic [7:0] d, input bit rdy);
        bit         have;
        bit         pop;
        bit         end_pkt;
        logic [9:0] e;
        have    = 1'b0;
        end_pkt = 1'b0;
        e       = '0;
        if (r) begin
            mq.delete();
            m_d = 8'h00; m_dir = 1'b0; m_nxt = 1'b0; m_prev = 1'b0;
            m_act = 1'b0; m_err = 1'b0; m_len = 8'h00; m_last = 8'h00;
            m_ovf = 1'b0; m_drop = 0;
        end else begin
            pop = rdy && (mq.size() != 0);
            if (m_dir && !m_prev) begin
                if (m_nxt) begin
                    m_act = 1'b1;
                    m_len = 8'h00;
                end
            end else if (m_dir && m_nxt) begin
                have  = 1'b1;
                e     = {2'b00, m_d};
                m_act = 1'b1;
                if (m_len != 8'hFF) m_len++;
            end else if (m_dir) begin
                if (m_d[5:4] == 2'b11) m_err = 1'b1;
                if (m_act && !m_d[4]) begin
                    end_pkt = 1'b1;
                end else if (m_d != m_last) begin
                    have   = 1'b1;
                    e      = {2'b01, m_d};
                    m_last = m_d;
                end
            end else if (m_prev && m_act) begin
                end_pkt = 1'b1;
            end
            if (end_pkt) begin
                have  = 1'b1;
                e     = {(m_err ? 2'b11 : 2'b10), m_len};
                m_act = 1'b0;
                m_err = 1'b0;
                m_len = 8'h00;
            end
            if (have && !pop && mq.size() == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
                have = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            if (have) mq.push_back(e);
            m_prev = m_dir;
            m_dir  = dir;
            m_nxt  = nxt;
            m_d    = d;
        end
    endtask

    task automatic cyc(input bit r, input bit dir, input bit nxt,
                       input logic [7:0] d, input bit rdy);
        rst      = r;
        DIR      = dir;
        NXT      = nxt;
        DATA     = d;
        rx_ready = rdy;
        model_edge(r, dir, nxt, d, rdy);
        @(posedge clk_ext);
        #1;
        chk("valid", 32'(rx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("head", 32'({rx_tag, rx_byte}), 32'(mq[0]));
        else chk("empty_out", 32'({rx_tag, rx_byte}), 32'(0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rx_active", 32'(rx_active), 32'(m_act));
        chk("stp", 32'(STP), 32'(0));
    endtask

    task automatic expect_pop(input string tag, input logic [1:0] t,
                              input logic [7:0] b);
        chk({tag, "_valid"}, 32'(rx_valid), 32'(1));
        chk(tag, 32'({rx_tag, rx_byte}), 32'({t, b}));
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        bit         rdir;
        bit         rrdy;
        logic [7:0] rdat;
        int         sel;

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_valid", 32'(rx_valid), 32'(0));
        chk("rst_byte", 32'(rx_byte), 32'(0));
        chk("rst_tag", 32'(rx_tag), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_drop", 32'(drop_cnt), 32'(0));
        chk("rst_active", 32'(rx_active), 32'(0));
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // basic packet
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        chk("lat_edge1", 32'(rx_valid), 32'(0));
        cyc(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
        chk("lat_edge2", 32'(rx_valid), 32'(1));
        cyc(1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("basic_level", 32'(level), 32'(4));
        expect_pop("basic0", 2'b00, 8'hA5);
        expect_pop("basic1", 2'b00, 8'h5A);
        expect_pop("basic2", 2'b00, 8'hC3);
        expect_pop("basic_eop", 2'b10, 8'h03);
        chk("basic_empty", 32'(rx_valid), 32'(0));

        // RX CMD framing
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("frame_level", 32'(level), 32'(4));
        expect_pop("frame_cmd", 2'b01, 8'h10);
        expect_pop("frame0", 2'b00, 8'h11);
        expect_pop("frame1", 2'b00, 8'h22);
        expect_pop("frame_eop", 2'b10, 8'h02);

        // dedup of repeated RX CMD outside a packet
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h0C, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("dedup_level", 32'(level), 32'(1));
        expect_pop("dedup_cmd", 2'b01, 8'h0C);

        // packet error flagged by RX CMD 0x30
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h30, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_pop("err_cmd", 2'b01, 8'h30);
        expect_pop("err_data", 2'b00, 8'h55);
        expect_pop("err_eop", 2'b11, 8'h01);

        // overflow: 20 bytes with the consumer stalled
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_level", 32'(level), 32'(16));
        chk("ovf_flag", 32'(ovf), 32'(1));
        chk("ovf_drops", 32'(drop_cnt), 32'(5));
        for (int i = 0; i < 16; i++) expect_pop("ovf_drain", 2'b00, 8'(8'h40 + i));
        chk("ovf_empty", 32'(rx_valid), 32'(0));

        // full FIFO with a simultaneous pop every cycle
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        chk("full_level", 32'(level), 32'(16));
        for (int i = 17; i < 27; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h80 + i), 1'b1);
            chk("fullpop_level", 32'(level), 32'(16));
            chk("fullpop_drop", 32'(drop_cnt), 32'(5));
        end
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("fullpop_empty", 32'(rx_valid), 32'(0));

        // reset in the middle of a packet
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h02, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h03, 1'b0);
        chk("midrst_valid0", 32'(rx_valid), 32'(0));
        cyc(1'b1, 1'b1, 1'b1, 8'h04, 1'b0);
        chk("midrst_valid1", 32'(rx_valid), 32'(0));
        chk("midrst_ovf", 32'(ovf), 32'(0));
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h7E, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_level", 32'(level), 32'(2));
        expect_pop("midrst_data", 2'b00, 8'h7E);
        expect_pop("midrst_eop", 2'b10, 8'h01);
        chk("midrst_empty", 32'(rx_valid), 32'(0));

        // randomized bus traffic with bursty consumer
        rdir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) rdir = ~rdir;
            sel = $urandom_range(0, 5);
            case (sel)
                0: rdat = 8'h00;
                1: rdat = 8'h0C;
                2: rdat = 8'h10;
                3: rdat = 8'h30;
                4: rdat = 8'h2E;
                default: rdat = 8'($urandom);
            endcase
            if (((i / 150) % 2) == 1) rrdy = ($urandom_range(0, 9) < 2);
            else rrdy = ($urandom_range(0, 9) < 8);
            cyc($urandom_range(0, 599) == 0, rdir, $urandom_range(0, 2) != 0,
                rdat, rrdy);
        end
        for (int i = 0; i < DEPTH + 8; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("final_empty", 32'(rx_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
